// File: rtl/spi_reg_if.sv
// spi_reg_if: APB register front-end for an SPI shift core (CR1/CR2/BR/SR/DR),
// transfer load FSM and interrupt. Optional build macro: SPI_OVERRUN_EN (overrun flag).
`timescale 1ns/1ps
module spi_reg_if (
  input  logic       clk_in,
  input  logic       rstn_in,
  input  logic       psel_in,
  input  logic       penable_in,
  input  logic       pwrite_in,
  input  logic [2:0] paddr_in,
  input  logic [7:0] pwdata_in,
  output logic [7:0] prdata_out,
  output logic       pready_out,
  output logic [7:0] spi_cr1_out,
  output logic [7:0] spi_dr_out,
  output logic       bidiroe_out,
  output logic       spc0_out,
  output logic       spie_out,
  output logic       sptie_out,
  output logic       errie_out,
  output logic [2:0] sppr_out,
  output logic [2:0] spr_out,
  input  logic       finished_in,
  input  logic [7:0] shift_in,
  input  logic       mode_fault_in,
  output logic       start_out,
  output logic       busy_out,
  output logic       irq_out
);

  localparam logic [2:0] ADDR_CR1 = 3'd0;
  localparam logic [2:0] ADDR_CR2 = 3'd1;
  localparam logic [2:0] ADDR_BR  = 3'd2;
  localparam logic [2:0] ADDR_SR  = 3'd3;
  localparam logic [2:0] ADDR_DR  = 3'd5;

  localparam int unsigned SPE_BIT    = 6;
  localparam int unsigned MTSR_BIT   = 5;
  localparam int unsigned MODFEN_BIT = 1;

  localparam logic [7:0] CR2_MASK  = 8'hB3;
  localparam logic [7:0] BR_MASK   = 8'h77;
  localparam logic [7:0] CR1_RESET = 8'h04;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    BUSY
  } state_e;

  state_e     state_q;
  logic       start_q;
  logic       busy_q;
  logic [7:0] dr_q;

  logic [7:0] cr1_q, cr1_d;
  logic [7:0] cr2_q, cr2_d;
  logic [7:0] br_q, br_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_q, tx_d;
  logic       tx_pend_q, tx_pend_d;
  logic       spif_q, spif_d;
  logic       ovr_q, ovr_d;
  logic       sptef_q, sptef_d;
  logic       modf_q, modf_d;
  logic       spif_arm_q, spif_arm_d;
  logic       modf_arm_q, modf_arm_d;
  logic       fin_q, fin_d;
  logic       mf_q, mf_d;
  logic       irq_q, irq_d;

  logic       wr_en, rd_en;
  logic       wr_cr1, wr_cr2, wr_br, wr_dr;
  logic       rd_sr, rd_dr;
  logic       fin_rise, mf_rise;
  logic       abort, done;
  logic [7:0] sr_val;

  assign wr_en    = psel_in & penable_in & pwrite_in;
  assign rd_en    = psel_in & penable_in & ~pwrite_in;
  assign wr_cr1   = wr_en & (paddr_in == ADDR_CR1);
  assign wr_cr2   = wr_en & (paddr_in == ADDR_CR2);
  assign wr_br    = wr_en & (paddr_in == ADDR_BR);
  assign wr_dr    = wr_en & (paddr_in == ADDR_DR);
  assign rd_sr    = rd_en & (paddr_in == ADDR_SR);
  assign rd_dr    = rd_en & (paddr_in == ADDR_DR);

  assign fin_rise = finished_in & ~fin_q;
  assign mf_rise  = mode_fault_in & ~mf_q;

  // Disabling SPE kills the transfer outright; a completion racing the abort is dropped.
  assign abort    = wr_cr1 & ~pwdata_in[SPE_BIT];
  assign done     = fin_rise & (state_q == BUSY) & ~abort;

  assign sr_val   = {spif_q, ovr_q, sptef_q, modf_q, 4'b0000};

  always_comb begin
    prdata_out = '0;
    case (paddr_in)
      ADDR_CR1: prdata_out = cr1_q;
      ADDR_CR2: prdata_out = cr2_q;
      ADDR_BR:  prdata_out = br_q;
      ADDR_SR:  prdata_out = sr_val;
      ADDR_DR:  prdata_out = rx_q;
      default:  prdata_out = '0;
    endcase
  end

  always_comb begin
    cr1_d      = cr1_q;
    cr2_d      = cr2_q;
    br_d       = br_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    tx_pend_d  = tx_pend_q;
    spif_d     = spif_q;
    ovr_d      = ovr_q;
    sptef_d    = sptef_q;
    modf_d     = modf_q;
    spif_arm_d = spif_arm_q;
    modf_arm_d = modf_arm_q;
    fin_d      = finished_in;
    mf_d       = mode_fault_in;

    if (wr_cr1) begin
      cr1_d = pwdata_in;
      if (modf_arm_q) begin
        modf_d     = 1'b0;
        modf_arm_d = 1'b0;
      end
    end
    if (abort) begin
      tx_pend_d = 1'b0;
      sptef_d   = 1'b1;
    end
    if (wr_cr2) cr2_d = pwdata_in & CR2_MASK;
    if (wr_br)  br_d  = pwdata_in & BR_MASK;

    if (wr_dr && sptef_q) begin
      tx_d      = pwdata_in;
      tx_pend_d = 1'b1;
      sptef_d   = 1'b0;
    end
    if (state_q == LOAD) begin
      tx_pend_d = 1'b0;
      sptef_d   = 1'b1;
    end

    if (rd_sr && spif_q) spif_arm_d = 1'b1;
    if (rd_sr && modf_q) modf_arm_d = 1'b1;
    if (rd_dr && spif_arm_q) begin
      spif_d     = 1'b0;
      ovr_d      = 1'b0;
      spif_arm_d = 1'b0;
    end

    // Set paths come last so a same-cycle set beats the clear (the arm stays dropped).
    if (done) begin
`ifdef SPI_OVERRUN_EN
      if (spif_q) ovr_d = 1'b1;
      else        rx_d  = shift_in;
`else
      rx_d = shift_in;
`endif
      spif_d = 1'b1;
    end
    if (mf_rise && cr1_q[MODFEN_BIT]) begin
      modf_d           = 1'b1;
      cr1_d[SPE_BIT]   = 1'b0;
      cr1_d[MTSR_BIT]  = 1'b0;
    end
  end

  assign irq_d = (cr2_q[7] & spif_q) | (cr2_q[5] & sptef_q) | (cr2_q[4] & (modf_q | ovr_q));

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      cr1_q      <= CR1_RESET;
      cr2_q      <= '0;
      br_q       <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      tx_pend_q  <= 1'b0;
      spif_q     <= 1'b0;
      ovr_q      <= 1'b0;
      sptef_q    <= 1'b1;
      modf_q     <= 1'b0;
      spif_arm_q <= 1'b0;
      modf_arm_q <= 1'b0;
      fin_q      <= 1'b0;
      mf_q       <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      cr1_q      <= cr1_d;
      cr2_q      <= cr2_d;
      br_q       <= br_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      tx_pend_q  <= tx_pend_d;
      spif_q     <= spif_d;
      ovr_q      <= ovr_d;
      sptef_q    <= sptef_d;
      modf_q     <= modf_d;
      spif_arm_q <= spif_arm_d;
      modf_arm_q <= modf_arm_d;
      fin_q      <= fin_d;
      mf_q       <= mf_d;
      irq_q      <= irq_d;
    end
  end

  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      dr_q    <= '0;
    end else if (abort) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tx_pend_q && cr1_q[SPE_BIT]) begin
            state_q <= LOAD;
            start_q <= 1'b1;
            busy_q  <= 1'b1;
            dr_q    <= tx_q;
          end else begin
            start_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        LOAD: begin
          state_q <= BUSY;
          start_q <= 1'b0;
          busy_q  <= 1'b1;
        end
        BUSY: begin
          start_q <= 1'b0;
          if (fin_rise) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          start_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pready_out  = 1'b1;
  assign spi_cr1_out = cr1_q;
  assign spi_dr_out  = dr_q;
  assign spie_out    = cr2_q[7];
  assign sptie_out   = cr2_q[5];
  assign errie_out   = cr2_q[4];
  assign bidiroe_out = cr2_q[1];
  assign spc0_out    = cr2_q[0];
  assign sppr_out    = br_q[6:4];
  assign spr_out     = br_q[2:0];
  assign start_out   = start_q;
  assign busy_out    = busy_q;
  assign irq_out     = irq_q;

endmodule

// File: tb/tb_spi_reg_if.sv
// tb_spi_reg_if: directed, table-driven bench for spi_reg_if.
`timescale 1ns/1ps
module tb_spi_reg_if;

  logic       clk_in = 1'b0;
  logic       rstn_in = 1'b0;
  logic       psel_in = 1'b0;
  logic       penable_in = 1'b0;
  logic       pwrite_in = 1'b0;
  logic [2:0] paddr_in = '0;
  logic [7:0] pwdata_in = '0;
  logic [7:0] prdata_out;
  logic       pready_out;
  logic [7:0] spi_cr1_out;
  logic [7:0] spi_dr_out;
  logic       bidiroe_out, spc0_out, spie_out, sptie_out, errie_out;
  logic [2:0] sppr_out, spr_out;
  logic       finished_in = 1'b0;
  logic [7:0] shift_in = '0;
  logic       mode_fault_in = 1'b0;
  logic       start_out, busy_out, irq_out;

  spi_reg_if dut (
    .clk_in(clk_in), .rstn_in(rstn_in),
    .psel_in(psel_in), .penable_in(penable_in), .pwrite_in(pwrite_in),
    .paddr_in(paddr_in), .pwdata_in(pwdata_in), .prdata_out(prdata_out),
    .pready_out(pready_out), .spi_cr1_out(spi_cr1_out), .spi_dr_out(spi_dr_out),
    .bidiroe_out(bidiroe_out), .spc0_out(spc0_out), .spie_out(spie_out),
    .sptie_out(sptie_out), .errie_out(errie_out), .sppr_out(sppr_out),
    .spr_out(spr_out), .finished_in(finished_in), .shift_in(shift_in),
    .mode_fault_in(mode_fault_in), .start_out(start_out), .busy_out(busy_out),
    .irq_out(irq_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;

  always @(negedge clk_in) if (start_out) start_cnt++;

  typedef struct {
    logic       wr;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] exp_rd;
    logic       exp_irq;
  } vec_t;

  vec_t vecs[13];

`ifdef SPI_OVERRUN_EN
  localparam logic [7:0] SR_OVR = 8'hE0;
  localparam bit         OVR_ON = 1'b1;
`else
  localparam logic [7:0] SR_OVR = 8'hA0;
  localparam bit         OVR_ON = 1'b0;
`endif

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_in);
    psel_in = 1'b1; pwrite_in = 1'b1; paddr_in = a; pwdata_in = d;
    @(negedge clk_in);
    penable_in = 1'b1;
    @(negedge clk_in);
    psel_in = 1'b0; penable_in = 1'b0; pwrite_in = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk_in);
    psel_in = 1'b1; pwrite_in = 1'b0; paddr_in = a;
    @(negedge clk_in);
    penable_in = 1'b1;
    #1 d = prdata_out;
    @(negedge clk_in);
    psel_in = 1'b0; penable_in = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] d;
    apb_read(a, d);
    check(name, d, exp);
  endtask

  task automatic finish_pulse(input logic [7:0] rxb);
    @(negedge clk_in);
    shift_in = rxb; finished_in = 1'b1;
    @(negedge clk_in);
    finished_in = 1'b0;
    @(negedge clk_in);
  endtask

  task automatic do_xfer(input logic [7:0] tx, input logic [7:0] rxb);
    apb_write(3'd5, tx);
    repeat (3) @(negedge clk_in);
    finish_pulse(rxb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rd;
    int base;

    vecs[0]  = '{1'b0, 3'd3, 8'h00, 8'h20, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 8'h00, 8'h04, 1'b0};
    vecs[2]  = '{1'b0, 3'd1, 8'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 3'd2, 8'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b0};
    vecs[5]  = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 3'd1, 8'hFF, 8'hB3, 1'b1};
    vecs[7]  = '{1'b1, 3'd2, 8'hFF, 8'h77, 1'b1};
    vecs[8]  = '{1'b1, 3'd1, 8'h00, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 3'd4, 8'hFF, 8'h00, 1'b0};
    vecs[10] = '{1'b1, 3'd3, 8'hFF, 8'h20, 1'b0};
    vecs[11] = '{1'b1, 3'd0, 8'h3A, 8'h3A, 1'b0};
    vecs[12] = '{1'b1, 3'd0, 8'h04, 8'h04, 1'b0};

    repeat (3) @(negedge clk_in);
    rstn_in = 1'b1;
    @(negedge clk_in);

    check("rst_start", {7'd0, start_out}, 8'h00);
    check("rst_busy", {7'd0, busy_out}, 8'h00);
    check("rst_irq", {7'd0, irq_out}, 8'h00);
    check("rst_dr_out", spi_dr_out, 8'h00);
    check("rst_cr1_out", spi_cr1_out, 8'h04);
    check("pready", {7'd0, pready_out}, 8'h01);

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) apb_write(vecs[i].addr, vecs[i].data);
      apb_read(vecs[i].addr, rd);
      check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      repeat (2) @(negedge clk_in);
      check($sformatf("vec%0d_irq", i), {7'd0, irq_out}, {7'd0, vecs[i].exp_irq});
    end

    check("br_ff_fields", {2'b00, sppr_out, spr_out}, 8'h3F);
    apb_write(3'd2, 8'h35);
    check("br_35_fields", {2'b00, sppr_out, spr_out}, 8'h1D);
    apb_write(3'd1, 8'h93);
    check("cr2_fields", {3'b000, spie_out, sptie_out, errie_out, bidiroe_out, spc0_out}, 8'h17);
    apb_write(3'd1, 8'h00);
    apb_write(3'd2, 8'h00);

    // Basic transfer
    apb_write(3'd0, 8'hD0);
    base = start_cnt;
    apb_write(3'd5, 8'hA5);
    repeat (3) @(negedge clk_in);
    check("x1_start_pulses", 8'(start_cnt - base), 8'd1);
    check("x1_dr_out", spi_dr_out, 8'hA5);
    check("x1_busy", {7'd0, busy_out}, 8'h01);
    read_check("x1_sr_busy", 3'd3, 8'h20);
    finish_pulse(8'h3C);
    check("x1_busy_done", {7'd0, busy_out}, 8'h00);
    read_check("x1_sr_spif", 3'd3, 8'hA0);
    read_check("x1_dr_rx", 3'd5, 8'h3C);
    read_check("x1_sr_clr", 3'd3, 8'h20);

    // Two completions without clearing SPIF
    do_xfer(8'h55, 8'h11);
    do_xfer(8'h66, 8'h22);
    read_check("ovr_sr", 3'd3, SR_OVR);
    read_check("ovr_dr", 3'd5, OVR_ON ? 8'h11 : 8'h22);
    read_check("ovr_sr_clr", 3'd3, 8'h20);

    // Completion coinciding with the clearing DR read
    do_xfer(8'h12, 8'h41);
    read_check("race_sr_arm", 3'd3, 8'hA0);
    apb_write(3'd5, 8'h99);
    repeat (3) @(negedge clk_in);
    @(negedge clk_in);
    psel_in = 1'b1; pwrite_in = 1'b0; paddr_in = 3'd5;
    @(negedge clk_in);
    penable_in = 1'b1; shift_in = 8'h42; finished_in = 1'b1;
    #1 rd = prdata_out;
    @(negedge clk_in);
    psel_in = 1'b0; penable_in = 1'b0; finished_in = 1'b0;
    check("race_dr_old", rd, 8'h41);
    read_check("race_dr_noclr", 3'd5, OVR_ON ? 8'h41 : 8'h42);
    read_check("race_sr_kept", 3'd3, SR_OVR);
    read_check("race_dr_clr", 3'd5, OVR_ON ? 8'h41 : 8'h42);
    read_check("race_sr_clr", 3'd3, 8'h20);

    // Abort while busy with a second byte pending
    base = start_cnt;
    apb_write(3'd5, 8'h77);
    repeat (3) @(negedge clk_in);
    check("ab_busy", {7'd0, busy_out}, 8'h01);
    apb_write(3'd5, 8'h88);
    read_check("ab_sr_pend", 3'd3, 8'h00);
    apb_write(3'd0, 8'h90);
    check("ab_busy_off", {7'd0, busy_out}, 8'h00);
    read_check("ab_sr", 3'd3, 8'h20);
    finish_pulse(8'hEE);
    read_check("ab_sr_nodone", 3'd3, 8'h20);
    read_check("ab_dr_keep", 3'd5, OVR_ON ? 8'h41 : 8'h42);
    apb_write(3'd0, 8'hD0);
    repeat (5) @(negedge clk_in);
    check("ab_start_pulses", 8'(start_cnt - base), 8'd1);
    check("ab_busy_idle", {7'd0, busy_out}, 8'h00);

    // Mode fault
    apb_write(3'd1, 8'h10);
    apb_write(3'd0, 8'h50);
    mode_fault_in = 1'b1;
    repeat (2) @(negedge clk_in);
    read_check("mf_off_cr1", 3'd0, 8'h50);
    read_check("mf_off_sr", 3'd3, 8'h20);
    mode_fault_in = 1'b0;
    apb_write(3'd0, 8'hD2);
    mode_fault_in = 1'b1;
    repeat (2) @(negedge clk_in);
    check("mf_cr1_out", spi_cr1_out, 8'h92);
    read_check("mf_cr1_rd", 3'd0, 8'h92);
    check("mf_irq", {7'd0, irq_out}, 8'h01);
    read_check("mf_sr", 3'd3, 8'h30);
    apb_write(3'd0, 8'h04);
    read_check("mf_sr_clr", 3'd3, 8'h20);
    repeat (2) @(negedge clk_in);
    check("mf_irq_clr", {7'd0, irq_out}, 8'h00);
    mode_fault_in = 1'b0;
    apb_write(3'd1, 8'h00);

    // Reset in the middle of a transfer
    apb_write(3'd0, 8'hD0);
    apb_write(3'd5, 8'h5C);
    repeat (3) @(negedge clk_in);
    check("mr_busy", {7'd0, busy_out}, 8'h01);
    #2 rstn_in = 1'b0;
    #1;
    check("mr_busy_rst", {7'd0, busy_out}, 8'h00);
    check("mr_start_rst", {7'd0, start_out}, 8'h00);
    check("mr_dr_out_rst", spi_dr_out, 8'h00);
    check("mr_cr1_rst", spi_cr1_out, 8'h04);
    @(negedge clk_in);
    rstn_in = 1'b1;
    finish_pulse(8'hAA);
    read_check("mr_sr", 3'd3, 8'h20);
    read_check("mr_dr", 3'd5, 8'h00);
    check("mr_irq", {7'd0, irq_out}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_if.md
SPI_REG_IF -- requirements
Module: spi_reg_if

Interface
REQ-001 SHALL have ports: clk_in  input  1  system clock; rstn_in  input  1  reset, asynchronous, active-low.
REQ-002 SHALL have APB slave ports: psel_in in 1; penable_in in 1; pwrite_in in 1; paddr_in in 3; pwdata_in in 8; prdata_out out 8; pready_out out 1, tied 1.
REQ-003 SHALL drive core control: spi_cr1_out out 8; spi_dr_out out 8; bidiroe_out, spc0_out, spie_out, sptie_out, errie_out out 1 each; sppr_out out 3; spr_out out 3.
REQ-004 SHALL accept core status: finished_in in 1, transfer done; shift_in in 8, received byte; mode_fault_in in 1.
REQ-005 SHALL drive start_out out 1 (one-cycle load pulse), busy_out out 1, and irq_out out 1.

Function
REQ-006 Register map: 0 CR1; 1 CR2 = {SPIE[7], SPTIE[5], ERRIE[4], BIDIROE[1], SPC0[0]}; 2 BR = {SPPR[6:4], SPR[2:0]}; 3 SR read-only = {SPIF[7], OVR[6], SPTEF[5], MODF[4]}; 5 DR; other addresses read 0, writes ignored.
REQ-007 Writes commit on the clk_in edge where psel_in & penable_in & pwrite_in; reads are side-effect-qualified on the same access condition with pwrite_in=0.
REQ-008 prdata_out is combinational from paddr_in; unimplemented bits read 0; DR reads return the rx buffer.
REQ-009 DR write with SPTEF=1 loads tx holding register and clears SPTEF; DR write with SPTEF=0 is ignored.
REQ-010 Load FSM states IDLE, LOAD, BUSY. IDLE->LOAD when tx pending and CR1.SPE=1. In LOAD: spi_dr_out <= tx holding, start_out=1 for one cycle, SPTEF set, then ->BUSY.
REQ-011 BUSY->IDLE on the rising edge of finished_in (registered edge detect). busy_out=1 in LOAD and BUSY.
REQ-012 On completion, shift_in is captured into rx buffer and SPIF set; if a tx byte is pending, the next LOAD follows in the cycle after IDLE, with no gap beyond that.
REQ-013 SPIF clear: SR read with SPIF=1 arms; a subsequent DR read clears SPIF and OVR; any other access in between does not disarm.
REQ-014 SPIF set and SPIF clear in the same cycle: set wins, and the arm is cancelled.
REQ-015 MODF set on a mode_fault_in rising edge when CR1.MODFEN=1; it forces CR1.SPE and CR1.MTSR to 0 on the same edge.
REQ-016 MODF clear: SR read with MODF=1 followed by a CR1 write.
REQ-017 CR1.SPE written 0 SHALL abort: FSM->IDLE, pending tx discarded, SPTEF=1; SPIF/rx buffer unchanged.
REQ-018 irq_out is registered: (SPIE & SPIF) | (SPTIE & SPTEF) | (ERRIE & (MODF | OVR)).
REQ-019 spi_cr1_out, CR2 fields and BR fields are direct register outputs with no latency beyond the write edge.

Reset
REQ-020 On rstn_in low: CR1=0x04, CR2=0x00, BR=0x00, rx/tx/spi_dr_out=0x00, SPIF=0, OVR=0, MODF=0, SPTEF=1.
REQ-021 On rstn_in low: FSM=IDLE, start_out=0, busy_out=0, irq_out=0, clear-arm flags=0, edge detectors=0.
REQ-022 Reset mid-transfer discards all state with no completion recorded.

Configuration
REQ-023 Macro SPI_OVERRUN_EN defined: completion with SPIF=1 sets OVR and leaves the rx buffer unchanged.
REQ-024 Without SPI_OVERRUN_EN: OVR reads 0, that completion overwrites the rx buffer, and SPIF stays 1.

Verification
REQ-025 Reset then read SR -> 0x20; read CR1 -> 0x04; irq_out=0.
REQ-026 CR1=0xD0, DR write 0xA5 -> start_out one pulse, spi_dr_out=0xA5, SPTEF=1; finished_in edge with shift_in=0x3C -> SPIF=1, DR read after SR read returns 0x3C, SPIF=0.
REQ-027 Two completions without clearing SPIF (0x11, then 0x22) -> with macro OVR=1, DR=0x11; without macro OVR=0, DR=0x22.
REQ-028 CR1=0xD2, mode_fault_in 0->1 -> MODF=1, CR1=0x92; with ERRIE=1, irq_out=1; SR read then CR1 write -> MODF=0.
REQ-029 DR write while BUSY, then CR1.SPE=0 before completion -> FSM IDLE, SPTEF=1, no further start_out pulse.
REQ-030 SR read while SPIF=1, then completion and DR read in the same cycle -> SPIF stays 1.
